// File: rtl/vu_vmu_roq_gen.sv
// Reorder queue for the vector memory unit load path: in-order tags, out-of-order fills, in-order dequeue.
// Optional same-cycle head bypass is enabled by defining VU_VMU_ROQ_BYPASS_EN.
module vu_vmu_roq_gen #(
  parameter int DATA_W      = 130,
  parameter int DEPTH       = 256,
  parameter int TAG_W       = 8,
  parameter int ALLOC_LIMIT = 256
) (
  input  logic              clk,
  input  logic              reset,
  output logic [TAG_W-1:0]  alloc_tag_bits,
  output logic              alloc_tag_val,
  input  logic              alloc_tag_rdy,
  input  logic              fill_val,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  output logic [DATA_W-1:0] deq_data_bits,
  output logic              deq_data_val,
  input  logic              deq_data_rdy,
  output logic [TAG_W:0]    count,
  output logic              fill_err
);

  localparam logic [TAG_W:0]   LIMIT   = (TAG_W+1)'(ALLOC_LIMIT);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  alloc_q, alloc_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    cnt_q, cnt_d;
  logic              fill_err_q, fill_err_d;

  logic alloc_fire_s;
  logic fill_legal_s;
  logic bypass_s;
  logic deq_fire_s;
  logic wr_en_s;

  // Handshake decode and output views of the queue state.
  always_comb begin
    alloc_tag_val  = (cnt_q < LIMIT);
    alloc_tag_bits = tail_q;
    count          = cnt_q;
    fill_err       = fill_err_q;
    alloc_fire_s   = alloc_tag_val & alloc_tag_rdy;
    fill_legal_s   = fill_val & alloc_q[fill_tag] & ~filled_q[fill_tag];
`ifdef VU_VMU_ROQ_BYPASS_EN
    // A legal fill can only target the head while the head is still unfilled.
    bypass_s       = fill_legal_s & (fill_tag == head_q);
    deq_data_val   = filled_q[head_q] | bypass_s;
    if (bypass_s) begin
      deq_data_bits = fill_data;
    end else begin
      deq_data_bits = data_q[head_q];
    end
`else
    bypass_s       = 1'b0;
    deq_data_val   = filled_q[head_q];
    deq_data_bits  = data_q[head_q];
`endif
    deq_fire_s     = deq_data_val & deq_data_rdy;
    wr_en_s        = fill_legal_s & ~(bypass_s & deq_data_rdy);
  end

  // Next-state for tag bookkeeping, pointers, occupancy and the error flag.
  always_comb begin
    alloc_d    = alloc_q;
    filled_d   = filled_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_err_d = fill_err_q | (fill_val & ~fill_legal_s);

    if (wr_en_s) begin
      filled_d[fill_tag] = 1'b1;
    end else begin
      filled_d = filled_d;
    end

    if (deq_fire_s) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + TAG_ONE;
    end else begin
      head_d = head_q;
    end

    // tail never equals a live head here: that needs cnt == DEPTH, where allocation is closed.
    if (alloc_fire_s) begin
      alloc_d[tail_q] = 1'b1;
      tail_d          = tail_q + TAG_ONE;
    end else begin
      tail_d = tail_q;
    end

    case ({alloc_fire_s, deq_fire_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_q    <= {DEPTH{1'b0}};
      filled_q   <= {DEPTH{1'b0}};
      head_q     <= {TAG_W{1'b0}};
      tail_q     <= {TAG_W{1'b0}};
      cnt_q      <= {(TAG_W+1){1'b0}};
      fill_err_q <= 1'b0;
    end else begin
      alloc_q    <= alloc_d;
      filled_q   <= filled_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      fill_err_q <= fill_err_d;
    end
  end

  // Response storage; contents are qualified by filled bits, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      data_q[fill_tag] <= fill_data;
    end
  end

endmodule

// File: tb/tb_vu_vmu_roq_gen.sv
// Self-checking bench for vu_vmu_roq_gen (DEPTH=8, ALLOC_LIMIT=4) with a data scoreboard.
`timescale 1ns/1ps
module tb_vu_vmu_roq_gen;

  logic         clk;
  logic         reset;
  logic [2:0]   alloc_tag_bits;
  logic         alloc_tag_val;
  logic         alloc_tag_rdy;
  logic         fill_val;
  logic [2:0]   fill_tag;
  logic [129:0] fill_data;
  logic [129:0] deq_data_bits;
  logic         deq_data_val;
  logic         deq_data_rdy;
  logic [3:0]   count;
  logic         fill_err;

  int           n_checks;
  int           n_fail;
  logic [129:0] sb[$];
  logic [129:0] exp_d;

  vu_vmu_roq_gen #(.DATA_W(130), .DEPTH(8), .TAG_W(3), .ALLOC_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .alloc_tag_bits(alloc_tag_bits), .alloc_tag_val(alloc_tag_val), .alloc_tag_rdy(alloc_tag_rdy),
    .fill_val(fill_val), .fill_tag(fill_tag), .fill_data(fill_data),
    .deq_data_bits(deq_data_bits), .deq_data_val(deq_data_val), .deq_data_rdy(deq_data_rdy),
    .count(count), .fill_err(fill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [129:0] mk_data(input int s);
    mk_data = {2'b10, 64'hDEAD_BEEF_0000_0000 | 64'(s), 64'(s) ^ 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic idle();
    alloc_tag_rdy = 1'b0;
    fill_val      = 1'b0;
    fill_tag      = 3'd0;
    fill_data     = 130'd0;
    deq_data_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #3;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_checks++; if (alloc_tag_val !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_val: got %0b expected 1", alloc_tag_val); end
    n_checks++; if (alloc_tag_bits !== 3'd0) begin n_fail++; $display("FAIL rst_alloc_bits: got %0d expected 0", alloc_tag_bits); end
    n_checks++; if (deq_data_val !== 1'b0) begin n_fail++; $display("FAIL rst_deq_val: got %0b expected 0", deq_data_val); end
    n_checks++; if (fill_err !== 1'b0) begin n_fail++; $display("FAIL rst_fill_err: got %0b expected 0", fill_err); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_in_order();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); alloc_tag_rdy = 1'b1; #1;
      n_checks++; if (alloc_tag_val !== 1'b1 || alloc_tag_bits !== 3'(t)) begin n_fail++; $display("FAIL io_alloc: got val %0b tag %0d expected val 1 tag %0d", alloc_tag_val, alloc_tag_bits, t); end
      sb.push_back(130'(8'hA0 + t));
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); alloc_tag_rdy = 1'b0; fill_val = 1'b1; fill_tag = 3'(t); fill_data = 130'(8'hA0 + t); #1;
      if (t == 0) begin
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL io_count3: got %0d expected 3", count); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fill_val = 1'b0; deq_data_rdy = 1'b1; #1;
      exp_d = sb.pop_front();
      n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d) begin n_fail++; $display("FAIL io_deq: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, exp_d); end
      n_checks++; if (count !== 4'(3 - i)) begin n_fail++; $display("FAIL io_count: got %0d expected %0d", count, 3 - i); end
    end
    @(negedge clk); deq_data_rdy = 1'b0; #1;
    n_checks++; if (count !== 4'd0 || deq_data_val !== 1'b0) begin n_fail++; $display("FAIL io_empty: got count %0d val %0b expected count 0 val 0", count, deq_data_val); end
  endtask

  task automatic test_out_of_order();
    logic [2:0] order [3];
    order[0] = 3'd3; order[1] = 3'd1; order[2] = 3'd2;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); alloc_tag_rdy = 1'b1; #1;
      n_checks++; if (alloc_tag_val !== 1'b1 || alloc_tag_bits !== 3'(t)) begin n_fail++; $display("FAIL ooo_alloc: got val %0b tag %0d expected val 1 tag %0d", alloc_tag_val, alloc_tag_bits, t); end
      sb.push_back(mk_data(200 + t));
    end
    @(negedge clk); alloc_tag_rdy = 1'b0; #1;
    n_checks++; if (alloc_tag_val !== 1'b0 || count !== 4'd4) begin n_fail++; $display("FAIL ooo_full: got val %0b count %0d expected val 0 count 4", alloc_tag_val, count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fill_val = 1'b1; fill_tag = order[i]; fill_data = mk_data(200 + int'(order[i])); #1;
      n_checks++; if (deq_data_val !== 1'b0) begin n_fail++; $display("FAIL ooo_hold: got val %0b expected 0", deq_data_val); end
    end
    @(negedge clk); fill_tag = 3'd0; fill_data = mk_data(200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); fill_val = 1'b0; deq_data_rdy = 1'b1; #1;
      exp_d = sb.pop_front();
      n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d) begin n_fail++; $display("FAIL ooo_deq: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, exp_d); end
    end
    @(negedge clk); deq_data_rdy = 1'b0; #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL ooo_count: got %0d expected 0", count); end
  endtask

  task automatic test_limit_wrap();
    logic [2:0] tags [4];
    int exp_tail;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); alloc_tag_rdy = 1'b1; #1;
      sb.push_back(mk_data(t));
    end
    @(negedge clk); alloc_tag_rdy = 1'b0; fill_val = 1'b1; fill_tag = 3'd0; fill_data = mk_data(0); #1;
    n_checks++; if (alloc_tag_val !== 1'b0 || count !== 4'd4) begin n_fail++; $display("FAIL lim_full: got val %0b count %0d expected val 0 count 4", alloc_tag_val, count); end
    @(negedge clk); fill_val = 1'b0; deq_data_rdy = 1'b1; #1;
    exp_d = sb.pop_front();
    n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d) begin n_fail++; $display("FAIL lim_deq0: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, exp_d); end
    n_checks++; if (alloc_tag_val !== 1'b0) begin n_fail++; $display("FAIL lim_still_full: got %0b expected 0", alloc_tag_val); end
    @(negedge clk); deq_data_rdy = 1'b0; #1;
    n_checks++; if (alloc_tag_val !== 1'b1 || count !== 4'd3) begin n_fail++; $display("FAIL lim_reopen: got val %0b count %0d expected val 1 count 3", alloc_tag_val, count); end
    for (int t = 1; t < 4; t++) begin
      @(negedge clk); fill_val = 1'b1; fill_tag = 3'(t); fill_data = mk_data(t);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fill_val = 1'b0; deq_data_rdy = 1'b1; #1;
      exp_d = sb.pop_front();
      n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d) begin n_fail++; $display("FAIL lim_drain: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, exp_d); end
    end
    exp_tail = 4;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); deq_data_rdy = 1'b0; alloc_tag_rdy = 1'b1; #1;
        n_checks++; if (alloc_tag_val !== 1'b1 || alloc_tag_bits !== 3'(exp_tail)) begin n_fail++; $display("FAIL wrap_alloc: got val %0b tag %0d expected val 1 tag %0d", alloc_tag_val, alloc_tag_bits, exp_tail); end
        tags[i] = 3'(exp_tail);
        sb.push_back(mk_data(4 + b * 4 + i));
        exp_tail = (exp_tail + 1) % 8;
      end
      for (int i = 3; i >= 0; i--) begin
        @(negedge clk); alloc_tag_rdy = 1'b0; fill_val = 1'b1; fill_tag = tags[i]; fill_data = mk_data(4 + b * 4 + i);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); fill_val = 1'b0; deq_data_rdy = 1'b1; #1;
        exp_d = sb.pop_front();
        n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d) begin n_fail++; $display("FAIL wrap_deq: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, exp_d); end
      end
    end
    @(negedge clk); deq_data_rdy = 1'b0; #1;
    n_checks++; if (count !== 4'd0 || deq_data_val !== 1'b0) begin n_fail++; $display("FAIL wrap_end: got count %0d val %0b expected count 0 val 0", count, deq_data_val); end
  endtask

  task automatic test_illegal_fill();
    do_reset();
    @(negedge clk); fill_val = 1'b1; fill_tag = 3'd5; fill_data = mk_data(55); #1;
    n_checks++; if (fill_err !== 1'b0) begin n_fail++; $display("FAIL ill_pre: got %0b expected 0", fill_err); end
    @(negedge clk); fill_val = 1'b0; #1;
    n_checks++; if (fill_err !== 1'b1 || deq_data_val !== 1'b0) begin n_fail++; $display("FAIL ill_unalloc: got err %0b val %0b expected err 1 val 0", fill_err, deq_data_val); end
    do_reset();
    @(negedge clk); alloc_tag_rdy = 1'b1; sb.push_back(mk_data(60));
    @(negedge clk); alloc_tag_rdy = 1'b0; fill_val = 1'b1; fill_tag = 3'd0; fill_data = mk_data(60);
    @(negedge clk); fill_data = mk_data(61); #1;
    n_checks++; if (fill_err !== 1'b0 || deq_data_val !== 1'b1) begin n_fail++; $display("FAIL ill_first_fill: got err %0b val %0b expected err 0 val 1", fill_err, deq_data_val); end
    @(negedge clk); fill_val = 1'b0; #1;
    n_checks++; if (fill_err !== 1'b1) begin n_fail++; $display("FAIL ill_dup: got %0b expected 1", fill_err); end
    @(negedge clk); deq_data_rdy = 1'b1; #1;
    exp_d = sb.pop_front();
    n_checks++; if (deq_data_bits !== exp_d) begin n_fail++; $display("FAIL ill_data_kept: got %0h expected %0h", deq_data_bits, exp_d); end
    @(negedge clk); deq_data_rdy = 1'b0; #1;
    n_checks++; if (fill_err !== 1'b1 || deq_data_val !== 1'b0) begin n_fail++; $display("FAIL ill_sticky: got err %0b val %0b expected err 1 val 0", fill_err, deq_data_val); end
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); alloc_tag_rdy = 1'b1; sb.push_back(mk_data(70 + t));
    end
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); alloc_tag_rdy = 1'b0; fill_val = 1'b1; fill_tag = 3'(t); fill_data = mk_data(70 + t);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); fill_val = (i == 0); fill_tag = 3'd7; fill_data = mk_data(99); #1;
      n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== sb[0]) begin n_fail++; $display("FAIL bp_stable: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, sb[0]); end
    end
    n_checks++; if (fill_err !== 1'b1 || count !== 4'd2) begin n_fail++; $display("FAIL bp_pre_reset: got err %0b count %0d expected err 1 count 2", fill_err, count); end
    @(negedge clk); fill_val = 1'b0; #2; reset = 1'b0; #1;
    n_checks++; if (count !== 4'd0 || deq_data_val !== 1'b0 || alloc_tag_bits !== 3'd0 || fill_err !== 1'b0) begin n_fail++; $display("FAIL async_rst: got count %0d val %0b tag %0d err %0b expected 0 0 0 0", count, deq_data_val, alloc_tag_bits, fill_err); end
    sb.delete();
    @(negedge clk); reset = 1'b1; fill_val = 1'b1; fill_tag = 3'd1; fill_data = mk_data(71);
    @(negedge clk); fill_val = 1'b0; #1;
    n_checks++; if (fill_err !== 1'b1 || deq_data_val !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL late_fill: got err %0b val %0b count %0d expected err 1 val 0 count 0", fill_err, deq_data_val, count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); alloc_tag_rdy = 1'b1; sb.push_back(mk_data(80));
    @(negedge clk); alloc_tag_rdy = 1'b0; fill_val = 1'b1; fill_tag = 3'd0; fill_data = mk_data(80);
    @(negedge clk); fill_val = 1'b0;
    @(negedge clk); alloc_tag_rdy = 1'b1; deq_data_rdy = 1'b1; sb.push_back(mk_data(81)); #1;
    exp_d = sb.pop_front();
    n_checks++; if (deq_data_bits !== exp_d || alloc_tag_bits !== 3'd1 || count !== 4'd1) begin n_fail++; $display("FAIL b2b_both: got data %0h tag %0d count %0d expected data %0h tag 1 count 1", deq_data_bits, alloc_tag_bits, count, exp_d); end
    @(negedge clk); alloc_tag_rdy = 1'b0; deq_data_rdy = 1'b0; #1;
    n_checks++; if (count !== 4'd1 || deq_data_val !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt: got count %0d val %0b expected count 1 val 0", count, deq_data_val); end
    fill_val = 1'b1; fill_tag = 3'd1; fill_data = mk_data(81);
    @(negedge clk); fill_val = 1'b0; deq_data_rdy = 1'b1; #1;
    exp_d = sb.pop_front();
    n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d) begin n_fail++; $display("FAIL b2b_deq: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, exp_d); end
    @(negedge clk); deq_data_rdy = 1'b0; #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL b2b_end: got %0d expected 0", count); end
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk); alloc_tag_rdy = 1'b1; sb.push_back(mk_data(90));
    @(negedge clk); alloc_tag_rdy = 1'b0; fill_val = 1'b1; fill_tag = 3'd0; fill_data = mk_data(90); deq_data_rdy = 1'b1; #1;
`ifdef VU_VMU_ROQ_BYPASS_EN
    exp_d = sb.pop_front();
    n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d || count !== 4'd1) begin n_fail++; $display("FAIL byp_same: got val %0b data %0h count %0d expected val 1 data %0h count 1", deq_data_val, deq_data_bits, count, exp_d); end
    @(negedge clk); fill_val = 1'b0; deq_data_rdy = 1'b0; #1;
    n_checks++; if (count !== 4'd0 || deq_data_val !== 1'b0) begin n_fail++; $display("FAIL byp_after: got count %0d val %0b expected count 0 val 0", count, deq_data_val); end
`else
    n_checks++; if (deq_data_val !== 1'b0) begin n_fail++; $display("FAIL nobyp_same: got val %0b expected 0", deq_data_val); end
    @(negedge clk); fill_val = 1'b0; #1;
    exp_d = sb.pop_front();
    n_checks++; if (deq_data_val !== 1'b1 || deq_data_bits !== exp_d) begin n_fail++; $display("FAIL nobyp_next: got val %0b data %0h expected val 1 data %0h", deq_data_val, deq_data_bits, exp_d); end
    @(negedge clk); deq_data_rdy = 1'b0; #1;
    n_checks++; if (count !== 4'd0 || deq_data_val !== 1'b0) begin n_fail++; $display("FAIL nobyp_after: got count %0d val %0b expected count 0 val 0", count, deq_data_val); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_limit_wrap();
    test_illegal_fill();
    test_backpressure_reset();
    test_back_to_back();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
